// File: rtl/i16_mode_scheduler.sv
// Intra-16x16 mode search scheduler: walks the enabled prediction modes,
// launches the reconstruct datapath per mode and keeps the lowest score.
module i16_mode_scheduler #(
   parameter int SCORE_W = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mb_valid,
   input  logic [3:0]         mode_mask,
   output logic               mb_ready,
   output logic               recon_start,
   output logic [1:0]         recon_mode,
   input  logic               recon_done,
   input  logic [SCORE_W-1:0] recon_score,
   input  logic [31:0]        recon_nz,
   output logic               best_valid,
   input  logic               best_ready,
   output logic [1:0]         best_mode,
   output logic [SCORE_W-1:0] best_score,
   output logic [31:0]        best_nz,
   output logic               best_err,
   output logic               busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [1:0]         state_q, state_d;
   logic [3:0]         mask_q, mask_d;
   logic [1:0]         mode_q, mode_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [1:0]         bmode_q, bmode_d;
   logic [SCORE_W-1:0] bscore_q, bscore_d;
   logic [31:0]        bnz_q, bnz_d;
   logic               err_q, err_d;
   logic               empty_q, empty_d;

   logic               mode_end;
   logic [2:0]         pick;
   logic [3:0]         above;

   // Returns {found, index} of the lowest set bit.
   function automatic logic [2:0] first_set(input logic [3:0] m);
      if (m[0])      return 3'b100;
      else if (m[1]) return 3'b101;
      else if (m[2]) return 3'b110;
      else if (m[3]) return 3'b111;
      else           return 3'b000;
   endfunction

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      mode_d   = mode_q;
      wd_d     = wd_q;
      bmode_d  = bmode_q;
      bscore_d = bscore_q;
      bnz_d    = bnz_q;
      err_d    = err_q;
      empty_d  = empty_q;
      mode_end = 1'b0;
      above    = mask_q & (4'b1110 << mode_q);
      pick     = first_set(above);
      case (state_q)
         S_IDLE: begin
            if (mb_valid && mb_ready) begin
               pick     = first_set(mode_mask);
               mask_d   = mode_mask;
               mode_d   = pick[1:0];
               err_d    = (mode_mask == 4'b0000);
               empty_d  = 1'b1;
               bmode_d  = 2'd0;
               bscore_d = '1;
               bnz_d    = '0;
               state_d  = pick[2] ? S_LAUNCH : S_DONE;
            end
         end
         S_LAUNCH: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_q + WD_W'(1);
            // A done arriving on the expiry cycle still counts as done.
            if (recon_done) begin
               mode_end = 1'b1;
               if (empty_q || (recon_score < bscore_q)) begin
                  empty_d  = 1'b0;
                  bmode_d  = mode_q;
                  bscore_d = recon_score;
                  bnz_d    = recon_nz;
               end
            end else if (wd_q == WD_LAST) begin
               mode_end = 1'b1;
               err_d    = 1'b1;
            end
            if (mode_end) begin
               mode_d  = pick[2] ? pick[1:0] : mode_q;
               state_d = pick[2] ? S_LAUNCH : S_DONE;
            end
         end
         S_DONE: begin
            if (best_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mask_q   <= '0;
         mode_q   <= '0;
         wd_q     <= '0;
         bmode_q  <= '0;
         bscore_q <= '0;
         bnz_q    <= '0;
         err_q    <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         mode_q   <= mode_d;
         wd_q     <= wd_d;
         bmode_q  <= bmode_d;
         bscore_q <= bscore_d;
         bnz_q    <= bnz_d;
         err_q    <= err_d;
         empty_q  <= empty_d;
      end
   end

   assign mb_ready    = (state_q == S_IDLE) && !rst;
   assign recon_start = (state_q == S_LAUNCH);
   assign recon_mode  = mode_q;
   assign best_valid  = (state_q == S_DONE);
   assign best_mode   = bmode_q;
   assign best_score  = bscore_q;
   assign best_nz     = bnz_q;
   assign best_err    = err_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_i16_mode_scheduler.sv
// Directed bench for i16_mode_scheduler: vector table of searches with a
// reactive datapath model, plus hold, reset and spurious-done sequences.
module tb_i16_mode_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mb_valid = 1'b0;
   logic [3:0]  mode_mask = 4'b0;
   logic        mb_ready;
   logic        recon_start;
   logic [1:0]  recon_mode;
   logic        recon_done = 1'b0;
   logic [31:0] recon_score = '0;
   logic [31:0] recon_nz = '0;
   logic        best_valid;
   logic        best_ready = 1'b0;
   logic [1:0]  best_mode;
   logic [31:0] best_score;
   logic [31:0] best_nz;
   logic        best_err;
   logic        busy;

   int n_chk = 0;
   int n_fail = 0;

   i16_mode_scheduler #(.SCORE_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .mb_valid(mb_valid), .mode_mask(mode_mask), .mb_ready(mb_ready),
      .recon_start(recon_start), .recon_mode(recon_mode),
      .recon_done(recon_done), .recon_score(recon_score),
      .recon_nz(recon_nz),
      .best_valid(best_valid), .best_ready(best_ready),
      .best_mode(best_mode), .best_score(best_score), .best_nz(best_nz),
      .best_err(best_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]        mask;
      logic [3:0][31:0]  sc;
      logic [3:0][3:0]   dl;   // cycles from start to done, 0 = never
      int                hold;
      logic [1:0]        e_mode;
      logic [31:0]       e_score;
      logic [31:0]       e_nz;
      logic              e_err;
   } vec_t;

   vec_t tv[9];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] nz_of(input int m);
      return 32'hC0DE_0000 | 32'(m);
   endfunction

   function automatic int next_bit(input logic [3:0] m, input int prev);
      for (int b = prev + 1; b < 4; b++) if (m[b]) return b;
      return -1;
   endfunction

   task automatic set_vec(input int i, input logic [3:0] m,
      input logic [31:0] s0, s1, s2, s3,
      input logic [3:0] d0, d1, d2, d3, input int hold,
      input logic [1:0] em, input logic [31:0] es, input logic [31:0] en,
      input logic ee);
      tv[i].mask = m;
      tv[i].sc = {s3, s2, s1, s0};
      tv[i].dl = {d3, d2, d1, d0};
      tv[i].hold = hold;
      tv[i].e_mode = em;
      tv[i].e_score = es;
      tv[i].e_nz = en;
      tv[i].e_err = ee;
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int starts, due, exp_next, exp_m, cur, vk, d;
      string p;
      logic [1:0] hm;
      logic [31:0] hs, hn;
      logic he;
      v = tv[i];
      p = $sformatf("v%0d", i);
      starts = 0; due = -1; exp_next = 1; exp_m = -1; cur = 0; vk = -1;
      @(negedge clk);
      chk({p, ".ready_idle"}, 64'(mb_ready), 64'd1);
      mb_valid = 1'b1;
      mode_mask = v.mask;
      for (int k = 1; k < 200; k++) begin
         @(negedge clk);
         mb_valid = 1'b0;
         recon_done = 1'b0;
         if (recon_start) begin
            exp_m = next_bit(v.mask, exp_m);
            chk($sformatf("%s.start%0d_cyc", p, starts), 64'(k),
                64'(exp_next));
            chk($sformatf("%s.start%0d_mode", p, starts),
                64'(recon_mode), 64'(exp_m));
            cur = int'(recon_mode);
            d = int'(v.dl[cur]);
            due = (d > 0 && d <= 8) ? k + d : -1;
            exp_next = ((due >= 0) ? due : k + 8) + 1;
            starts++;
         end
         if (k == due) begin
            chk({p, ".mode_stable"}, 64'(recon_mode), 64'(cur));
            recon_done = 1'b1;
            recon_score = v.sc[cur];
            recon_nz = nz_of(cur);
         end
         if (best_valid) begin
            vk = k;
            break;
         end
      end
      recon_done = 1'b0;
      chk({p, ".n_starts"}, 64'(starts), 64'($countones(v.mask)));
      chk({p, ".valid_cyc"}, 64'(vk), 64'(exp_next));
      chk({p, ".best_mode"}, 64'(best_mode), 64'(v.e_mode));
      chk({p, ".best_score"}, 64'(best_score), 64'(v.e_score));
      chk({p, ".best_nz"}, 64'(best_nz), 64'(v.e_nz));
      chk({p, ".best_err"}, 64'(best_err), 64'(v.e_err));
      hm = best_mode; hs = best_score; hn = best_nz; he = best_err;
      for (int h = 0; h < v.hold; h++) begin
         mb_valid = 1'b1;
         mode_mask = 4'b1111;
         @(negedge clk);
         chk({p, ".hold_stable"}, {best_valid, mb_ready, busy, he, hm,
             hs, hn[23:0]}, {3'b101, best_err, best_mode, best_score,
             best_nz[23:0]});
         chk({p, ".hold_nz"}, 64'(best_nz), 64'(hn));
      end
      mb_valid = 1'b0;
      best_ready = 1'b1;
      @(negedge clk);
      best_ready = 1'b0;
      chk({p, ".release"}, {mb_ready, best_valid, busy}, 3'b100);
   endtask

   initial begin
      int seen_start, seen_valid;
      set_vec(0, 4'b1111, 40, 25, 25, 60, 5, 5, 5, 5, 20,
              2'd1, 25, 32'hC0DE_0001, 1'b0);
      set_vec(1, 4'b1010, 0, 9, 0, 3, 5, 5, 5, 5, 0,
              2'd3, 3, 32'hC0DE_0003, 1'b0);
      set_vec(2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0,
              2'd0, 32'hFFFF_FFFF, 32'h0, 1'b1);
      set_vec(3, 4'b0011, 0, 7, 0, 0, 0, 5, 0, 0, 0,
              2'd1, 7, 32'hC0DE_0001, 1'b1);
      set_vec(4, 4'b0011, 20, 7, 0, 0, 8, 5, 0, 0, 0,
              2'd1, 7, 32'hC0DE_0001, 1'b0);
      set_vec(5, 4'b0101, 1, 1, 1, 1, 0, 0, 0, 0, 0,
              2'd0, 32'hFFFF_FFFF, 32'h0, 1'b1);
      set_vec(6, 4'b0100, 0, 0, 0, 0, 0, 0, 1, 0, 0,
              2'd2, 0, 32'hC0DE_0002, 1'b0);
      set_vec(7, 4'b1100, 0, 0, 10, 10, 0, 0, 2, 3, 0,
              2'd2, 10, 32'hC0DE_0002, 1'b0);
      set_vec(8, 4'b1001, 32'h8000_0000, 0, 0, 32'h7FFF_FFFF,
              4, 0, 0, 4, 0, 2'd3, 32'h7FFF_FFFF, 32'hC0DE_0003, 1'b0);

      // Reset state
      #12;
      chk("reset_outs", {mb_ready, recon_start, recon_mode, best_valid,
          best_mode, best_err, busy}, '0);
      chk("reset_data", {best_score, best_nz}, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 64'(mb_ready), 64'd1);

      for (int i = 0; i < 9; i++) run_vec(i);

      // Reset in the middle of a search
      @(negedge clk);
      mb_valid = 1'b1;
      mode_mask = 4'b1111;
      @(negedge clk);
      mb_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_outs", {mb_ready, recon_start, recon_mode, best_valid,
          best_mode, best_err, busy}, '0);
      chk("mid_rst_data", {best_score, best_nz}, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_ready", 64'(mb_ready), 64'd1);
      recon_done = 1'b1;
      recon_score = 32'd1;
      seen_start = 0;
      seen_valid = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         recon_done = 1'b0;
         if (recon_start) seen_start++;
         if (best_valid || busy) seen_valid++;
      end
      chk("spur_no_start", 64'(seen_start), 64'd0);
      chk("spur_no_result", 64'(seen_valid), 64'd0);

      // Scheduler still works after the abandoned search
      run_vec(1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/i16_mode_scheduler.md
I16_MODE_SCHEDULER -- requirements
Module: i16_mode_scheduler

Interface
REQ-001 SHALL have parameter SCORE_W, default 32, width of rate-distortion score per mode.
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum cycles waited for recon_done per mode.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port mb_valid, input, 1, macroblock search request.
REQ-006 SHALL have port mode_mask, input, 4, enabled modes (bit0 DC, bit1 TM, bit2 V, bit3 H), sampled on accept.
REQ-007 SHALL have port mb_ready, output, 1, scheduler can accept a request.
REQ-008 SHALL have port recon_start, output, 1, one-cycle start pulse to the reconstruct datapath.
REQ-009 SHALL have port recon_mode, output, 2, mode index under evaluation, stable from recon_start until recon_done or timeout.
REQ-010 SHALL have port recon_done, input, 1, datapath completion pulse.
REQ-011 SHALL have port recon_score, input, SCORE_W, unsigned score, valid with recon_done.
REQ-012 SHALL have port recon_nz, input, 32, nz mask, valid with recon_done.
REQ-013 SHALL have port best_valid, output, 1, result available.
REQ-014 SHALL have port best_ready, input, 1, consumer accepts result.
REQ-015 SHALL have port best_mode / best_score / best_nz, output, 2 / SCORE_W / 32, winning mode, its score and nz.
REQ-016 SHALL have port best_err, output, 1, result flagged: empty mask or at least one mode timed out.
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT, DONE.
REQ-019 IDLE: mb_ready=1; on mb_valid&&mb_ready SHALL latch mode_mask, clear best_err, mark best as empty, go LAUNCH with recon_mode = lowest set mask bit.
REQ-020 IDLE with latched mask 4'b0000 SHALL go directly to DONE with best_mode=0, best_score=all ones, best_nz=0, best_err=1.
REQ-021 LAUNCH SHALL assert recon_start for exactly one cycle, clear watchdog counter, go WAIT.
REQ-022 WAIT SHALL increment watchdog each cycle; recon_done SHALL end the mode; watchdog reaching TIMEOUT without recon_done SHALL end the mode, set best_err, discard that mode.
REQ-023 recon_done in the same cycle as watchdog expiry SHALL be treated as done (no error).
REQ-024 On done, SHALL update best when best is empty or recon_score < best_score (strict); ties keep the earlier (lower-index) mode.
REQ-025 After a mode ends, SHALL go LAUNCH with next higher set mask bit if one exists, else DONE.
REQ-026 Timing: accept at cycle T -> recon_start at T+1; done at cycle D -> next recon_start at D+1, or best_valid at D+1 after last mode.
REQ-027 DONE: best_valid=1 with best_* stable until best_valid&&best_ready, then IDLE (mb_ready=1 next cycle).
REQ-028 All modes timed out SHALL produce best_mode=0, best_score=all ones, best_nz=0, best_err=1.
REQ-029 recon_done outside WAIT SHALL be ignored; mb_valid outside IDLE SHALL be ignored (single request in flight).
REQ-030 Score compare SHALL be unsigned, full SCORE_W width, no saturation.

Reset
REQ-031 rst high SHALL asynchronously force state IDLE, watchdog 0, latched mask 0, and outputs mb_ready=0, recon_start=0, recon_mode=0, best_valid=0, best_mode=0, best_score=0, best_nz=0, best_err=0, busy=0.
REQ-032 mb_ready SHALL rise the first cycle after rst deasserts; reset mid-search SHALL abandon the search with no result emitted and no further recon_start.

Verification
REQ-033 Mask 4'b1111, scores 40,25,25,60 with done 5 cycles after each start -> 4 start pulses modes 0,1,2,3; best_mode=1, best_score=25, best_err=0.
REQ-034 Mask 4'b1010, scores 9,3 -> starts with modes 1 then 3 only; best_mode=3, best_score=3.
REQ-035 Mask 4'b0000 -> no recon_start; best_valid at T+1 with best_err=1, best_score=all ones.
REQ-036 TIMEOUT=8, mask 4'b0011, mode 0 never done, mode 1 score 7 -> mode 1 start exactly 9 cycles after mode 0 start; best_mode=1, best_err=1; done on expiry cycle variant -> best_err=0.
REQ-037 best_ready held low 20 cycles -> best_* stable, mb_ready=0, mb_valid ignored; accept on ready, mb_ready next cycle.
REQ-038 rst asserted in WAIT -> all outputs zero immediately; spurious recon_done after reset produces no result.
